// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : RV32I/RV64I opcodes and immediate-format encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_t;

endpackage

`default_nettype wire

// File: rtl/imm_ext.sv
// ============================================================================
// Module  : imm_ext
// Brief   : Combinational opcode classification and immediate sign-extension.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_ext #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    import riscv_pkg::*;

    // Immediate assembled and already sign-extended to 32 bits
    logic [31:0] w_val;
    imm_fmt_t    w_fmt;
    logic        w_ill;

    always_comb begin
        w_val = '0;
        w_fmt = FMT_ILL;
        w_ill = 1'b1;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: begin
                w_val = {{20{instr[31]}}, instr[31:20]};
                w_fmt = FMT_I;
                w_ill = 1'b0;
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    w_val = {{20{instr[31]}}, instr[31:20]};
                    w_fmt = FMT_I;
                    w_ill = 1'b0;
                end
            end
            STORE: begin
                w_val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                w_fmt = FMT_S;
                w_ill = 1'b0;
            end
            BRANCH: begin
                w_val = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                w_fmt = FMT_B;
                w_ill = 1'b0;
            end
            JAL: begin
                w_val = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                w_fmt = FMT_J;
                w_ill = 1'b0;
            end
            LUI, AUIPC: begin
                w_val = {instr[31:12], 12'b0};
                w_fmt = FMT_U;
                w_ill = 1'b0;
            end
            OP: begin
                w_fmt = FMT_R;
                w_ill = 1'b0;
            end
            OP_32: begin
                if (XLEN == 64) begin
                    w_fmt = FMT_R;
                    w_ill = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign fmt     = w_fmt;
    assign illegal = w_ill;

    generate
        if (XLEN > 32) begin : g_sext_wide
            assign imm = {{(XLEN-32){w_val[31]}}, w_val};
        end else begin : g_sext_narrow
            assign imm = w_val[XLEN-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module  : imm_decode_stage
// Brief   : Registered immediate-decode stage with skid buffer and illegal count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    import riscv_pkg::*;

    // Entry layout: {instr, imm, fmt, illegal}
    localparam int c_ENTRY_W = 32 + XLEN + 3 + 1;

    logic [XLEN-1:0]      w_dec_imm;
    logic [2:0]           w_dec_fmt;
    logic                 w_dec_ill;
    logic [c_ENTRY_W-1:0] w_new;
    logic                 w_in_ready;
    logic                 w_accept;

    logic [c_ENTRY_W-1:0] r_out;
    logic [c_ENTRY_W-1:0] r_skid;
    logic                 r_out_valid;
    logic                 r_skid_valid;
    logic [CNT_W-1:0]     r_cnt;

    imm_ext #(
        .XLEN (XLEN)
    ) u_imm_ext (
        .instr   (in_instr),
        .imm     (w_dec_imm),
        .fmt     (w_dec_fmt),
        .illegal (w_dec_ill)
    );

    assign w_new    = {in_instr, w_dec_imm, w_dec_fmt, w_dec_ill};
    assign w_accept = in_valid && w_in_ready && !flush;

    generate
        if (SKID != 0) begin : g_skid
            assign w_in_ready = !r_skid_valid;
        end else begin : g_noskid
            assign w_in_ready = !r_out_valid || out_ready;
        end
    endgenerate

    // Skid only fills while the output is stalled; a draining output pulls from skid first
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out        <= {32'b0, {XLEN{1'b0}}, FMT_R, 1'b0};
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid <= w_new;
                end
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_new;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (w_accept && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out[c_ENTRY_W-1 -: 32];
    assign out_imm     = r_out[4 +: XLEN];
    assign out_fmt     = r_out[1 +: 3];
    assign out_illegal = r_out[0];
    assign illegal_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// Module  : tb_imm_decode_stage
// Brief   : Scoreboard bench driving an XLEN=32 and an XLEN=64 (CNT_W=2) stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy32, ov32, ill32;
    logic [31:0] oi32, imm32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        rdy64, ov64, ill64;
    logic [31:0] oi64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [1:0]  cnt64;

    exp_t q32[$];
    exp_t q64[$];
    int   m32;
    int   m64;
    int   checks;
    int   errors;

    imm_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(16)) dut32 (
        .clk (clk), .n_rst (n_rst), .flush (flush),
        .in_valid (in_valid), .in_ready (rdy32), .in_instr (in_instr),
        .out_valid (ov32), .out_ready (out_ready), .out_instr (oi32),
        .out_imm (imm32), .out_fmt (fmt32), .out_illegal (ill32),
        .illegal_cnt (cnt32)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1), .CNT_W(2)) dut64 (
        .clk (clk), .n_rst (n_rst), .flush (flush),
        .in_valid (in_valid), .in_ready (rdy64), .in_instr (in_instr),
        .out_valid (ov64), .out_ready (out_ready), .out_instr (oi64),
        .out_imm (imm64), .out_fmt (fmt64), .out_illegal (ill64),
        .illegal_cnt (cnt64)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [31:0] w, bit is64);
        exp_t        e;
        logic [31:0] v;
        e.instr = w;
        e.fmt   = 3'd7;
        e.ill   = 1'b1;
        v       = 32'b0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = {{20{w[31]}}, w[31:20]}; e.fmt = 3'd1; e.ill = 1'b0;
            end
            7'h1B: begin
                if (is64) begin
                    v = {{20{w[31]}}, w[31:20]}; e.fmt = 3'd1; e.ill = 1'b0;
                end
            end
            7'h23: begin
                v = {{20{w[31]}}, w[31:25], w[11:7]}; e.fmt = 3'd2; e.ill = 1'b0;
            end
            7'h63: begin
                v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; e.fmt = 3'd3; e.ill = 1'b0;
            end
            7'h6F: begin
                v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; e.fmt = 3'd5; e.ill = 1'b0;
            end
            7'h37, 7'h17: begin
                v = {w[31:12], 12'b0}; e.fmt = 3'd4; e.ill = 1'b0;
            end
            7'h33: begin
                e.fmt = 3'd0; e.ill = 1'b0;
            end
            7'h3B: begin
                if (is64) begin
                    e.fmt = 3'd0; e.ill = 1'b0;
                end
            end
            default: ;
        endcase
        e.imm = {{32{v[31]}}, v};
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_ov32"}, 64'(ov32), 64'd0);
        chk({tag, "_rdy32"}, 64'(rdy32), 64'd1);
        chk({tag, "_oi32"}, 64'(oi32), 64'd0);
        chk({tag, "_imm32"}, 64'(imm32), 64'd0);
        chk({tag, "_fmt32"}, 64'(fmt32), 64'd0);
        chk({tag, "_ill32"}, 64'(ill32), 64'd0);
        chk({tag, "_cnt32"}, 64'(cnt32), 64'd0);
        chk({tag, "_ov64"}, 64'(ov64), 64'd0);
        chk({tag, "_rdy64"}, 64'(rdy64), 64'd1);
        chk({tag, "_imm64"}, imm64, 64'd0);
        chk({tag, "_cnt64"}, 64'(cnt64), 64'd0);
    endtask

    // One clock: score outputs consumed this cycle, record accepts, then check the model state
    task automatic step();
        exp_t e;
        bit   a32;
        bit   a64;
        a32 = in_valid && rdy32 && !flush;
        a64 = in_valid && rdy64 && !flush;
        if (ov32 && out_ready) begin
            checks++;
            assert (q32.size() > 0) else begin
                errors++;
                $error("FAIL sb32_underflow observed=out_valid expected=no_pending_entry");
            end
            if (q32.size() > 0) begin
                e = q32.pop_front();
                chk("d32_instr", 64'(oi32), 64'(e.instr));
                chk("d32_imm", 64'(imm32), {32'b0, e.imm[31:0]});
                chk("d32_fmt", 64'(fmt32), 64'(e.fmt));
                chk("d32_ill", 64'(ill32), 64'(e.ill));
            end
        end
        if (ov64 && out_ready) begin
            checks++;
            assert (q64.size() > 0) else begin
                errors++;
                $error("FAIL sb64_underflow observed=out_valid expected=no_pending_entry");
            end
            if (q64.size() > 0) begin
                e = q64.pop_front();
                chk("d64_instr", 64'(oi64), 64'(e.instr));
                chk("d64_imm", imm64, e.imm);
                chk("d64_fmt", 64'(fmt64), 64'(e.fmt));
                chk("d64_ill", 64'(ill64), 64'(e.ill));
            end
        end
        if (flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (a32) begin
                e = model(in_instr, 1'b0);
                q32.push_back(e);
                if (e.ill && m32 != 65535) m32++;
            end
            if (a64) begin
                e = model(in_instr, 1'b1);
                q64.push_back(e);
                if (e.ill && m64 != 3) m64++;
            end
        end
        @(posedge clk);
        #1;
        chk("v32", 64'(ov32), 64'(q32.size() != 0));
        chk("r32", 64'(rdy32), 64'(q32.size() < 2));
        chk("c32", 64'(cnt32), 64'(m32));
        chk("v64", 64'(ov64), 64'(q64.size() != 0));
        chk("r64", 64'(rdy64), 64'(q64.size() < 2));
        chk("c64", 64'(cnt64), 64'(m64));
    endtask

    initial begin
        clk       = 1'b0;
        n_rst     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        checks    = 0;
        errors    = 0;
        m32       = 0;
        m64       = 0;
        #1 n_rst = 1'b0;
        #1 reset_checks("rst");
        @(posedge clk);
        #1 n_rst = 1'b1;

        // Directed formats at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        step();
        chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
        chk("addi_fmt32", 64'(fmt32), 64'd1);
        chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        in_instr = 32'hFE112E23;
        step();
        chk("sw_imm32", 64'(imm32), 64'hFFFFFFFC);
        chk("sw_fmt32", 64'(fmt32), 64'd2);
        in_instr = 32'hFE000CE3;
        step();
        chk("beq_imm32", 64'(imm32), 64'hFFFFFFF8);
        chk("beq_fmt32", 64'(fmt32), 64'd3);
        in_instr = 32'h0010006F;
        step();
        chk("jal_imm32", 64'(imm32), 64'h00000800);
        chk("jal_fmt32", 64'(fmt32), 64'd5);
        in_instr = 32'h800000B7;
        step();
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_fmt64", 64'(fmt64), 64'd4);
        in_instr = 32'h0000003B;
        step();
        chk("op32_fmt64", 64'(fmt64), 64'd0);
        chk("op32_ill64", 64'(ill64), 64'd0);
        chk("op32_fmt32", 64'(fmt32), 64'd7);
        chk("op32_ill32", 64'(ill32), 64'd1);
        in_valid = 1'b0;
        step();

        // Backpressure: A out, B in skid, C held off, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        step();
        in_instr = 32'h00200113;
        step();
        in_instr = 32'h00300193;
        step();
        step();
        chk("stall_rdy32", 64'(rdy32), 64'd0);
        chk("stall_oi32", 64'(oi32), 64'h00100093);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Illegal counting and saturation of the 2-bit counter
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        repeat (3) step();
        chk("ill3_cnt64", 64'(cnt64), 64'd3);
        chk("ill3_cnt32", 64'(cnt32), 64'd4);
        chk("ill3_out32", 64'(ill32), 64'd1);
        repeat (2) step();
        chk("ill5_cnt64", 64'(cnt64), 64'd3);
        chk("ill5_cnt32", 64'(cnt32), 64'd6);
        in_valid = 1'b0;
        step();

        // Flush with skid full while offering an illegal D
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        step();
        in_instr = 32'h00200113;
        step();
        flush    = 1'b1;
        in_instr = 32'h00000000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ov32", 64'(ov32), 64'd0);
        chk("flush_rdy32", 64'(rdy32), 64'd1);
        chk("flush_cnt32", 64'(cnt32), 64'd6);

        // Flush while in_ready is high: the offered word must be discarded
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        step();
        flush    = 1'b1;
        in_instr = 32'h00000000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_ov64", 64'(ov64), 64'd0);
        chk("flush2_cnt32", 64'(cnt32), 64'd6);
        out_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        step();
        in_instr = 32'h00000000;
        step();
        #2 n_rst = 1'b0;
        #1 reset_checks("arst");
        q32.delete();
        q64.delete();
        m32      = 0;
        m64      = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFE112E23;
        step();
        chk("post_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        in_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage for the RV32I/RV64I front end. It accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its format. It produces a fully sign-extended XLEN-wide immediate, flags illegal opcodes and keeps a saturating illegal-instruction count. It sits between fetch and register-read and isolates both sides with a 2-entry skid buffer.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- SKID, 1: 1 = 2-entry skid buffer (full throughput, registered in_ready); 0 = single register, in_ready = !out_valid || out_ready.
- CNT_W, 16: width of illegal_cnt.

Clock and reset: one clock, `clk`; reset `n_rst` is asynchronous and active-low.

- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- out_valid  out  1  decoded result present
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction passed through
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  imm_fmt_t: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
- out_illegal  out  1  opcode not recognised
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Decode on opcode in_instr[6:0]; result is captured at accept.
- I-format (0010011, 0000011, 1100111; 0011011 only when XLEN=64): imm = sext(instr[31:20]).
- S-format (0100011): imm = sext({instr[31:25], instr[11:7]}).
- B-format (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- J-format (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- U-format (0110111, 0010111): imm = sext({instr[31:12], 12'b0}).
- R-format (0110011; 0111011 only when XLEN=64): imm = 0.
- Anything else: fmt = ILL, imm = 0, illegal = 1.
- sext always extends from bit 31 of the assembled value (bit 11/12/20/31 of the raw immediate) to XLEN.
- illegal_cnt increments by 1 on each accepted ILL instruction and holds at all-ones. flush does not clear it.
- Skid (SKID=1) works as follows.
  - Accept = in_valid && in_ready.
  - Out register is empty, or drains this cycle: the accepted entry goes to the out register.
  - Out register is stalled: the accepted entry goes to the skid register.
  - When the out register drains and the skid register is full, the skid entry moves to the out register.
  - in_ready = !skid_full.
- Order is strictly preserved. No entry is ever dropped or duplicated except on flush.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1.
  - out_instr, out_imm and out_illegal = 0; out_fmt = R.
  - illegal_cnt = 0; skid empty.
- Latency: accept in cycle N gives out_valid with data in cycle N+1.
- Throughput is 1 instruction per cycle while out_ready = 1.
- out_valid, once high, holds with stable data until out_ready.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains.
- flush:
  - Both entries are invalidated at the next edge, so out_valid = 0 in the following cycle.
  - An instruction offered in the flush cycle is not accepted. in_ready may be high, but the instruction is discarded and not counted.
  - in_ready = 1 after a flush.
- A simultaneous accept and drain with a full skid is legal. Skid moves to out and the new entry enters skid.
- Reset asserted mid-transfer clears both entries immediately, without waiting for a clock edge.

## Structure
- A shared package `riscv_pkg` holds the following.
  - Opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, JAL, LUI, AUIPC, OP, OP_IMM_32, OP_32).
  - imm_fmt_t enum.
- One natural sub-module: `imm_ext`. It is the combinational decode, parametrised by XLEN, with ports instr → imm, fmt, illegal. The stage owns registers, skid, counter and flush.

## Test plan
- XLEN=32, in_instr 0xFFF00093 (addi -1) → next cycle out_imm 0xFFFFFFFF, fmt I; 0xFE112E23 (sw -4) → 0xFFFFFFFC, fmt S.
- 0xFE000CE3 (beq −8) → 0xFFFFFFF8, fmt B; 0x0010006F (jal +2048) → 0x00000800, fmt J.
- XLEN=64, 0x800000B7 (lui 0x80000) → out_imm 0xFFFFFFFF80000000, fmt U; 0x0000003B → fmt R, not illegal; the same word at XLEN=32 → ILL.
- out_ready=0, stream A, B, C → A held at output, B in skid, in_ready low, C held off; then out_ready=1 → A, B, C emitted in order, no gaps once C accepted.
- 0x00000000 ×3 accepted → out_illegal=1, illegal_cnt=3. With CNT_W=2 and 5 illegals, the count saturates at 3.
- With skid full, pulse flush while offering D → out_valid=0 next cycle, D not emitted, illegal_cnt unchanged. Asserting n_rst low mid-stream returns all outputs to reset values immediately.
